// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: producer request bundle and FIFO write-side signals for fifo_write_arbiter
interface fifo_write_arbiter_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0] req_last;
    logic [NUM_REQ-1:0] req_ready;
    logic fifo_full;
    logic fifo_wen;
    logic [FIFO_WIDTH-1:0] fifo_din;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic busy;
    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input req_ready, fifo_wen, fifo_din, grant_id, busy
    );
    modport slave (
        input req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wen, fifo_din, grant_id, busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers
module fifo_write_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ = 4,
    parameter int MAX_BURST = 8,
    parameter int STALL_LIMIT = 16
) (
    input logic clk_a,
    input logic rst,
    fifo_write_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam int SW = $clog2(STALL_LIMIT) + 1;
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nx;
    logic [GW-1:0] grant_id, grant_nx, rr_ptr, rr_nx, pick;
    logic [BW-1:0] beat_cnt, beat_nx;
    logic [SW-1:0] stall_cnt, stall_nx;
    logic [FIFO_WIDTH-1:0] g_data;
    logic g_valid, g_last, open, accept;
    always_ff @(posedge clk_a) begin
        if (rst) begin
            state <= IDLE;
            grant_id <= '0;
            rr_ptr <= GW'(NUM_REQ - 1);
            beat_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            grant_id <= grant_nx;
            rr_ptr <= rr_nx;
            beat_cnt <= beat_nx;
            stall_cnt <= stall_nx;
        end
    end
    // later iterations win, so the loop runs from farthest to nearest after rr_ptr
    always_comb begin
        pick = rr_ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            logic [GW-1:0] idx;
            idx = GW'((int'(rr_ptr) + k) % NUM_REQ);
            if (bus.req_valid[idx]) pick = idx;
        end
    end
    always_comb begin
        g_valid = 1'b0;
        g_last = 1'b0;
        g_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == grant_id) begin
                g_valid = bus.req_valid[i];
                g_last = bus.req_last[i];
                g_data = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end
    assign open = state == BURST && !rst && !bus.fifo_full;
    assign accept = open && g_valid;
    assign bus.req_ready = open ? NUM_REQ'(1) << grant_id : '0;
    assign bus.fifo_wen = accept;
    assign bus.fifo_din = accept ? g_data : '0;
    assign bus.grant_id = grant_id;
    assign bus.busy = state == BURST;
    always_comb begin
        state_nx = state;
        grant_nx = grant_id;
        rr_nx = rr_ptr;
        beat_nx = beat_cnt;
        stall_nx = stall_cnt;
        if (state == IDLE) begin
            if (|bus.req_valid) begin
                state_nx = BURST;
                grant_nx = pick;
                beat_nx = '0;
                stall_nx = '0;
            end
        end else if (accept) begin
            beat_nx = beat_cnt + 1'b1;
            stall_nx = '0;
            if (g_last || beat_cnt == BW'(MAX_BURST - 1)) begin
                state_nx = IDLE;
                rr_nx = grant_id;
            end
        end else if (!g_valid) begin
            stall_nx = stall_cnt + 1'b1;
            if (stall_cnt == SW'(STALL_LIMIT - 1)) begin
                state_nx = IDLE;
                rr_nx = grant_id;
            end
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed vector table plus multi-cycle corner sequences for fifo_write_arbiter
module tb_fifo_write_arbiter;
    localparam int W = 16;
    localparam int N = 4;
    logic clk_a = 0;
    logic clk_b = 0;
    logic rst = 1;
    fifo_write_arbiter_if #(.FIFO_WIDTH(W), .NUM_REQ(N)) bus();
    fifo_write_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .MAX_BURST(8), .STALL_LIMIT(16)) dut (
        .clk_a(clk_a),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk_a = ~clk_a;
    initial begin
        #3;
        forever begin
            clk_b = 1;
            #10;
            clk_b = 0;
            #10;
        end
    end
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int seq[N];
    int blen[N];
    int lim[N];
    bit en[N];
    logic manual_full = 0;
    bit use_model = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int rd_goal = 0;
    logic o_wen, o_busy, o_full;
    logic [W-1:0] o_din;
    logic [N-1:0] o_ready;
    logic [1:0] o_gid;
    logic [W-1:0] w_din[$];
    int w_gid[$];
    int w_cyc[$];
    // 8-deep FIFO occupancy model: writes counted on clk_a, reads on clk_b
    assign bus.fifo_full = use_model ? (wr_cnt - rd_cnt >= 8) : manual_full;
    always @(posedge clk_b) if (rd_cnt < rd_goal && wr_cnt - rd_cnt > 0) rd_cnt <= rd_cnt + 1;
    typedef struct {
        bit full;
        logic wen;
        logic [W-1:0] din;
        logic [N-1:0] ready;
        logic busy;
        int gid;
    } vec_t;
    vec_t tbl[21];
    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic drive();
        logic [N-1:0] v, l;
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) begin
            v[i] = en[i] && seq[i] < lim[i];
            l[i] = blen[i] != 0 && seq[i] % blen[i] == blen[i] - 1;
            d[i*W +: W] = W'(i * 4096 + seq[i] % 4096);
        end
        bus.req_valid = v;
        bus.req_last = l;
        bus.req_data = d;
    endtask
    task automatic tick();
        @(negedge clk_a);
        o_wen = bus.fifo_wen;
        o_din = bus.fifo_din;
        o_ready = bus.req_ready;
        o_busy = bus.busy;
        o_gid = bus.grant_id;
        o_full = bus.fifo_full;
        chk("wen_while_full", 32'(o_wen && o_full), 0);
        if (o_wen) begin
            w_din.push_back(o_din);
            w_gid.push_back(int'(o_gid));
            w_cyc.push_back(cyc);
        end
        @(posedge clk_a);
        #1;
        cyc++;
        if (o_wen) wr_cnt++;
        for (int i = 0; i < N; i++) if (o_ready[i] && bus.req_valid[i]) seq[i]++;
        drive();
    endtask
    task automatic do_reset();
        rst = 1;
        manual_full = 0;
        use_model = 0;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            blen[i] = 0;
            lim[i] = 1000;
            en[i] = 0;
        end
        drive();
        tick();
        tick();
        rst = 0;
        w_din.delete();
        w_gid.delete();
        w_cyc.delete();
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        int r;
        bit full_seen;
        int e_id[15] = '{2, 2, 2, 2, 2, 2, 2, 2, 3, 3, 0, 0, 1, 1, 2};
        int e_sq[15] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 0, 1, 0, 1, 8};
        for (int g = 0; g < 5; g++) begin
            r = g % 4;
            tbl[g*4] = '{0, 0, 0, 0, 0, g == 0 ? 0 : (g - 1) % 4};
            for (int b = 0; b < 3; b++)
                tbl[g*4+1+b] = '{0, 1, W'(r * 4096 + (g / 4) * 3 + b), N'(1) << r, 1, r};
        end
        tbl[20] = '{0, 0, 0, 0, 0, 0};
        do_reset();
        tick();
        chk("rst_wen", o_wen, 0);
        chk("rst_ready", o_ready, 0);
        chk("rst_din", o_din, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_gid", o_gid, 0);
        for (int i = 0; i < N; i++) begin
            en[i] = 1;
            blen[i] = 3;
        end
        drive();
        for (int k = 0; k < 21; k++) begin
            manual_full = tbl[k].full;
            tick();
            chk($sformatf("t1_wen[%0d]", k), o_wen, int'(tbl[k].wen));
            chk($sformatf("t1_din[%0d]", k), o_din, int'(tbl[k].din));
            chk($sformatf("t1_ready[%0d]", k), o_ready, int'(tbl[k].ready));
            chk($sformatf("t1_busy[%0d]", k), o_busy, int'(tbl[k].busy));
            chk($sformatf("t1_gid[%0d]", k), o_gid, tbl[k].gid);
        end
        do_reset();
        en[2] = 1;
        drive();
        tick();
        tick();
        for (int i = 0; i < N; i++) if (i != 2) begin
            en[i] = 1;
            blen[i] = 2;
        end
        drive();
        for (int k = 0; k < 30; k++) tick();
        chk("t2_write_count", 32'(w_din.size() >= 15), 1);
        if (w_din.size() >= 15) begin
            for (int k = 0; k < 15; k++) begin
                chk($sformatf("t2_gid[%0d]", k), w_gid[k], e_id[k]);
                chk($sformatf("t2_din[%0d]", k), w_din[k], e_id[k] * 4096 + e_sq[k]);
            end
            chk("t2_burst_span", w_cyc[7] - w_cyc[0], 7);
            chk("t2_release_gap", w_cyc[8] - w_cyc[7], 2);
        end
        do_reset();
        en[1] = 1;
        blen[1] = 6;
        drive();
        tick();
        chk("t3_bubble_busy", o_busy, 0);
        repeat (4) tick();
        manual_full = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t3_full_wen[%0d]", k), o_wen, 0);
            chk($sformatf("t3_full_ready[%0d]", k), o_ready, 0);
            chk($sformatf("t3_full_busy[%0d]", k), o_busy, 1);
        end
        manual_full = 0;
        tick();
        chk("t3_resume_beat4", o_din, 'h1004);
        tick();
        chk("t3_last_beat5", o_din, 'h1005);
        tick();
        chk("t3_release_busy", o_busy, 0);
        chk("t3_total_beats", w_din.size(), 6);
        if (w_din.size() == 6)
            for (int k = 0; k < 6; k++) chk($sformatf("t3_din[%0d]", k), w_din[k], 'h1000 + k);
        do_reset();
        en[0] = 1;
        en[3] = 1;
        blen[3] = 1;
        drive();
        tick();
        tick();
        tick();
        en[0] = 0;
        drive();
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("t4_stall_busy[%0d]", k), o_busy, 1);
            chk($sformatf("t4_stall_wen[%0d]", k), o_wen, 0);
        end
        tick();
        chk("t4_released", o_busy, 0);
        tick();
        chk("t4_next_gid", o_gid, 3);
        chk("t4_next_din", o_din, 'h3000);
        chk("t4_next_wen", o_wen, 1);
        do_reset();
        en[1] = 1;
        drive();
        repeat (4) tick();
        rst = 1;
        en[0] = 1;
        drive();
        tick();
        chk("t5_rst_cycle_wen", o_wen, 0);
        chk("t5_rst_cycle_ready", o_ready, 0);
        rst = 0;
        tick();
        chk("t5_after_wen", o_wen, 0);
        chk("t5_after_ready", o_ready, 0);
        chk("t5_after_din", o_din, 0);
        chk("t5_after_busy", o_busy, 0);
        chk("t5_after_gid", o_gid, 0);
        tick();
        chk("t5_regrant_gid", o_gid, 0);
        chk("t5_regrant_din", o_din, 'h0000);
        chk("t5_regrant_wen", o_wen, 1);
        chk("t5_write_count", w_din.size(), 4);
        do_reset();
        wr_cnt = 0;
        use_model = 1;
        en[0] = 1;
        lim[0] = 10;
        drive();
        full_seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (o_full) full_seen = 1;
        end
        chk("t6_writes_until_full", w_din.size(), 8);
        chk("t6_full_seen", 32'(full_seen), 1);
        rd_goal = 2;
        for (int k = 0; k < 60 && w_din.size() < 10; k++) tick();
        repeat (5) tick();
        chk("t6_writes_after_reads", w_din.size(), 10);
        if (w_din.size() == 10)
            for (int k = 0; k < 10; k++) chk($sformatf("t6_din[%0d]", k), w_din[k], k);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Shares the single write port of the dual-clock FIFO (din_a/wen_a, clk_a domain) among NUM_REQ producers. It uses round-robin arbitration. A grant is held for a whole burst, so beats from one producer stay contiguous in the FIFO. The block throttles all writes on the FIFO full flag and never issues a write while full is high. It sits entirely in the clk_a domain, between the producers and the FIFO write side.

Parameters:
FIFO_WIDTH, 16, data width per beat; matches the FIFO din_a width.
NUM_REQ, 4, number of requesters (2..8).
MAX_BURST, 8, maximum beats per grant before forced release (>=1).
STALL_LIMIT, 16, consecutive cycles with the granted requester's valid low before forced release (>=1).

Ports:
clk_a  in  1  write-side clock.
rst  in  1  reset.
req_valid  in  NUM_REQ  per-requester beat valid.
req_data  in  NUM_REQ*FIFO_WIDTH  per-requester data; requester i uses bits [i*FIFO_WIDTH +: FIFO_WIDTH].
req_last  in  NUM_REQ  marks the final beat of a burst.
req_ready  out  NUM_REQ  beat accepted when valid&&ready.
fifo_full  in  1  FIFO full flag.
fifo_wen  out  1  to FIFO wen_a.
fifo_din  out  FIFO_WIDTH  to FIFO din_a.
grant_id  out  $clog2(NUM_REQ)  index of the current or most recent grantee.
busy  out  1  high while a grant is held.

Behaviour:
- Reset (rst is synchronous, active-high, sampled on clk_a):
  - state=IDLE, grant_id=0, rr_ptr=NUM_REQ-1 (requester 0 wins first), beat_cnt=0, stall_cnt=0.
  - Outputs: req_ready=0, fifo_wen=0, fifo_din=0, busy=0.
  - A reset mid-burst abandons the burst immediately. No write is issued in the reset cycle.
- FSM states:
  - IDLE:
    - req_ready=0 and fifo_wen=0.
    - If any req_valid is high: pick the first valid index searching from rr_ptr+1 upward, modulo NUM_REQ.
    - Register the pick into grant_id; clear beat_cnt and stall_cnt; go to BURST. This costs one arbitration bubble cycle.
  - BURST:
    - req_ready[grant_id] = !fifo_full (combinational). All other ready bits are 0.
    - fifo_wen = req_valid[grant_id] && !fifo_full.
    - fifo_din = granted data slice when fifo_wen=1, else 0. This is a combinational pass-through with no added latency.
    - On each accepted beat: beat_cnt++ and stall_cnt cleared.
    - Release occurs on an accepted beat with req_last=1, or on an accepted beat when beat_cnt==MAX_BURST-1.
    - Valid-low cycles: stall_cnt++ each cycle the grantee's valid is low. Release occurs when stall_cnt reaches STALL_LIMIT-1 while valid is still low.
    - Full-stall cycles (valid=1, full=1): beat_cnt and stall_cnt are both frozen. There is no forced release on full.
    - On release: rr_ptr=grant_id; go to IDLE. grant_id keeps its value.
- busy = (state==BURST).
- Full-flag handling:
  - The FIFO raises full on the same edge that writes its last slot. fifo_full is therefore valid for the next cycle's decision, and no extra margin is required.
  - fifo_wen is never 1 when fifo_full=1.
- Simultaneous events:
  - A request arriving in the release cycle is seen on the next IDLE cycle.
  - A former grantee that is the only valid requester is re-granted.
- All counters are sized $clog2 of their limit plus 1, so they cannot wrap.

Test Plan:
1. Reset, then req_valid=4'b1111, all data streams with req_last on the 3rd beat, fifo_full=0 -> grants 0,1,2,3,0 in order. Each burst is 3 consecutive fifo_wen cycles separated by 1 idle cycle. fifo_din carries the correct slices.
2. Requester 2 streams 20 beats with req_last=0, MAX_BURST=8 -> exactly 8 writes, forced release, then the other valid requesters are served before requester 2 is regranted.
3. fifo_full is held high for 5 cycles mid-burst on beat 4 -> fifo_wen=0 and req_ready=0 for those 5 cycles. The burst resumes with beat 4, and no beat is lost or duplicated.
4. The grantee drops valid after 2 beats, STALL_LIMIT=16 -> release after exactly 16 idle cycles; busy falls and the next requester is granted.
5. rst is asserted during beat 3 of a burst -> in the next cycle all outputs are 0 and state is IDLE. The next grant goes to requester 0.
6. Back-to-back integration with the FIFO (FIFO_DEPTH=8): 10 beats are offered -> exactly 8 are written, full=1 is observed, and the remaining 2 are accepted only after reads on clk_b free space.
